// File: rtl/vmem_arbiter.sv
// Video-memory arbiter: video reads get every cycle they ask for, CPU requests
// wait in a one-entry holding register and issue only in cycles video leaves free.
module vmem_arbiter #(
  parameter int ADDR_W   = 14,
  parameter int DATA_W   = 12,
  parameter int MAX_WAIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic [DATA_W-1:0] vid_data,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_starve,
  input  logic              starve_clr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_q
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);

  logic              hold_valid_q, hold_valid_d;
  logic              hold_we_q, hold_we_d;
  logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] hold_wdata_q, hold_wdata_d;
  logic              rd_pend_q, rd_pend_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              cpu_rvalid_q, cpu_rvalid_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic              cpu_starve_q, cpu_starve_d;
  logic              issue, accept, blocked, starve_set;

  assign issue      = hold_valid_q & ~vid_req;
  assign blocked    = hold_valid_q & vid_req;
  assign cpu_ready  = ~hold_valid_q | issue;
  assign accept     = cpu_valid & cpu_ready;
  assign vid_data   = mem_q;
  assign cpu_rvalid = cpu_rvalid_q;
  assign cpu_rdata  = cpu_rdata_q;
  assign cpu_starve = cpu_starve_q;

  // Memory port mux: video owns the port whenever it asks for it.
  always_comb begin
    mem_addr  = vid_addr;
    mem_we    = 1'b0;
    mem_wdata = hold_wdata_q;
    if (!vid_req && issue) begin
      mem_addr = hold_addr_q;
      mem_we   = hold_we_q;
    end
  end

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_we_d    = hold_we_q;
    hold_addr_d  = hold_addr_q;
    hold_wdata_d = hold_wdata_q;
    if (accept) begin
      hold_valid_d = 1'b1;
      hold_we_d    = cpu_we;
      hold_addr_d  = cpu_addr;
      hold_wdata_d = cpu_wdata;
    end else if (issue) begin
      hold_valid_d = 1'b0;
    end

    // Read data returns one cycle after issue, captured at the end of that cycle.
    rd_pend_d    = issue & ~hold_we_q;
    cpu_rvalid_d = rd_pend_q;
    cpu_rdata_d  = rd_pend_q ? mem_q : cpu_rdata_q;

    wait_cnt_d = '0;
    if (blocked) begin
      wait_cnt_d = (wait_cnt_q == WAIT_W'(MAX_WAIT)) ? wait_cnt_q : wait_cnt_q + WAIT_W'(1);
    end
    starve_set   = blocked & (wait_cnt_d == WAIT_W'(MAX_WAIT));
    cpu_starve_d = starve_set | (cpu_starve_q & ~starve_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      wait_cnt_q   <= '0;
      cpu_rvalid_q <= 1'b0;
      cpu_rdata_q  <= '0;
      cpu_starve_q <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      rd_pend_q    <= rd_pend_d;
      wait_cnt_q   <= wait_cnt_d;
      cpu_rvalid_q <= cpu_rvalid_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_starve_q <= cpu_starve_d;
    end
  end

  // Payload of the holding register is qualified by hold_valid_q, so it needs no reset.
  always_ff @(posedge clk) begin
    hold_we_q    <= hold_we_d;
    hold_addr_q  <= hold_addr_d;
    hold_wdata_q <= hold_wdata_d;
  end

endmodule

// File: tb/tb_vmem_arbiter.sv
// Bench for vmem_arbiter: memory macro model, transaction-level reference model
// checked every cycle, and directed scenarios with literal expectations.
module tb_vmem_arbiter;
  localparam int AW = 14;
  localparam int DW = 12;
  localparam int MW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          vid_req = 1'b0;
  logic [AW-1:0] vid_addr = '0;
  logic [DW-1:0] vid_data;
  logic          cpu_valid = 1'b0;
  logic          cpu_ready;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          cpu_starve;
  logic          starve_clr = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_q;

  always #5 clk = ~clk;

  vmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data),
    .cpu_valid(cpu_valid), .cpu_ready(cpu_ready), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .cpu_starve(cpu_starve), .starve_clr(starve_clr), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_q(mem_q)
  );

  // Memory macro: registered address, one-cycle read latency.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [AW-1:0] mem_raddr = '0;
  initial for (int i = 0; i < (1<<AW); i++) mem[i] = '0;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    mem_raddr <= mem_addr;
  end
  assign mem_q = mem[mem_raddr];

  int n_cmp = 0;
  int n_bad = 0;
  int we_cnt = 0;
  int rv_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: pending CPU requests as a queue, golden memory contents
  // updated when a request is granted the port.
  typedef struct packed {
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } req_t;
  req_t          pend[$];
  logic [DW-1:0] gold [0:(1<<AW)-1];
  initial for (int i = 0; i < (1<<AW); i++) gold[i] = '0;
  logic          s1_v = 1'b0;
  logic [DW-1:0] s1_d = '0;
  logic          m_rvalid = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_starve = 1'b0;
  int            blk = 0;
  logic          m_vid_v = 1'b0;
  logic [DW-1:0] m_vid_d = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pend.delete();
      s1_v = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_starve = 1'b0; blk = 0;
      m_vid_v = vid_req; m_vid_d = gold[vid_addr];
    end else begin
      logic has, go, rdy;
      req_t r;
      has = (pend.size() != 0);
      go  = has && !vid_req;
      rdy = !has || !vid_req;
      m_vid_v = vid_req;
      m_vid_d = gold[vid_addr];
      m_rvalid = s1_v;
      if (s1_v) m_rdata = s1_d;
      s1_v = 1'b0;
      if (has && vid_req) begin
        blk = (blk < MW) ? blk + 1 : MW;
        if (blk == MW) m_starve = 1'b1;
        else if (starve_clr) m_starve = 1'b0;
      end else begin
        blk = 0;
        if (starve_clr) m_starve = 1'b0;
      end
      if (go) begin
        r = pend.pop_front();
        if (r.we) gold[r.a] = r.d;
        else begin s1_v = 1'b1; s1_d = gold[r.a]; end
      end
      if (cpu_valid && rdy) pend.push_back('{cpu_we, cpu_addr, cpu_wdata});
    end
  end

  always @(negedge clk) begin
    if (mem_we) we_cnt++;
    if (cpu_rvalid) rv_cnt++;
    chk("cpu_ready", cpu_ready, (pend.size() == 0) || !vid_req);
    if (vid_req) chk("mem_addr_vid", mem_addr, vid_addr);
    if (!rst && pend.size() != 0 && !vid_req) begin
      chk("mem_addr_cpu", mem_addr, pend[0].a);
      chk("mem_we_cpu", mem_we, pend[0].we);
      if (pend[0].we) chk("mem_wdata", mem_wdata, pend[0].d);
    end else begin
      chk("mem_we_idle", mem_we, 1'b0);
    end
    chk("cpu_rvalid", cpu_rvalid, m_rvalid);
    chk("cpu_rdata", cpu_rdata, m_rdata);
    chk("cpu_starve", cpu_starve, m_starve);
    if (m_vid_v) chk("vid_data", vid_data, m_vid_d);
  end

  task automatic cyc(input logic vr, input logic [AW-1:0] va, input logic cv, input logic we,
                     input logic [AW-1:0] ca, input logic [DW-1:0] cw, input logic sc);
    vid_req = vr; vid_addr = va; cpu_valid = cv; cpu_we = we;
    cpu_addr = ca; cpu_wdata = cw; starve_clr = sc;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc(1'b0, AW'(k), 1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int sv_we, sv_rv, idx, guard;
    logic acc;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", cpu_ready, 1'b1);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_rvalid", cpu_rvalid, 1'b0);
    chk("rst_rdata", cpu_rdata, 12'h000);
    chk("rst_starve", cpu_starve, 1'b0);
    rst = 1'b0;
    idle(2);

    // Write then read back-to-back.
    sv_we = we_cnt; sv_rv = rv_cnt;
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0123, 12'h0A5, 1'b0);
    cyc(1'b0, 14'h1, 1'b1, 1'b0, 14'h0123, 12'h000, 1'b0);
    idle(4);
    chk("s1_we_count", we_cnt - sv_we, 1);
    chk("s1_rv_count", rv_cnt - sv_rv, 1);
    chk("s1_rdata", cpu_rdata, 12'h0A5);

    // Read pending across a 5-cycle video burst.
    cyc(1'b0, 14'h0, 1'b1, 1'b1, 14'h0200, 12'h321, 1'b0);
    idle(2);
    cyc(1'b1, 14'h0123, 1'b1, 1'b0, 14'h0200, 12'h000, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, 14'h0200 + AW'(k), 1'b0, 1'b0, 14'h3FFF, 12'hFFF, 1'b0);
    vid_req = 1'b0; #1;
    chk("s2_issue_addr", mem_addr, 14'h0200);
    @(posedge clk); #1;
    idle(3);
    chk("s2_rdata", cpu_rdata, 12'h321);

    // Prefill 0..15, then reads under alternating video traffic.
    for (int k = 0; k < 16; k++) cyc(1'b0, '0, 1'b1, 1'b1, AW'(k), 12'h100 + DW'(k), 1'b0);
    idle(2);
    sv_rv = rv_cnt; idx = 0; guard = 0;
    while (idx < 16 && guard < 200) begin
      vid_req = (guard % 2 == 0); vid_addr = 14'h0100 + AW'(guard % 20);
      cpu_valid = 1'b1; cpu_we = 1'b0; cpu_addr = AW'(idx); cpu_wdata = '0;
      @(negedge clk); acc = cpu_ready;
      @(posedge clk); #1;
      if (acc) idx++;
      guard++;
    end
    if (idx < 16) chk("s3_timeout", idx, 16);
    idle(5);
    chk("s3_rv_count", rv_cnt - sv_rv, 16);
    chk("s3_last_rdata", cpu_rdata, 12'h10F);

    // Starvation: request blocked MW cycles.
    cyc(1'b1, 14'h0, 1'b1, 1'b0, 14'h0123, 12'h000, 1'b0);
    for (int k = 0; k < MW - 1; k++) cyc(1'b1, AW'(k), 1'b0, 1'b0, '0, '0, 1'b0);
    chk("s4_starve_early", cpu_starve, 1'b0);
    cyc(1'b1, 14'h7, 1'b0, 1'b0, '0, '0, 1'b0);
    chk("s4_starve_set", cpu_starve, 1'b1);
    cyc(1'b1, 14'h8, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("s4_set_wins", cpu_starve, 1'b1);
    cyc(1'b0, 14'h9, 1'b0, 1'b0, '0, '0, 1'b1);
    chk("s4_cleared", cpu_starve, 1'b0);
    idle(3);
    chk("s4_rdata", cpu_rdata, 12'h0A5);

    // Reset while a read is in flight.
    sv_rv = rv_cnt;
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 14'h0005, 12'h000, 1'b0);
    cyc(1'b0, 14'h0, 1'b0, 1'b0, 14'h0000, 12'h000, 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("s5_rst_rdata", cpu_rdata, 12'h000);
    chk("s5_rst_ready", cpu_ready, 1'b1);
    chk("s5_rst_mem_we", mem_we, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    idle(4);
    chk("s5_no_rvalid", rv_cnt - sv_rv, 0);
    chk("s5_rdata", cpu_rdata, 12'h000);
    chk("s5_ready", cpu_ready, 1'b1);

    // Held write with cpu_valid dropped during a video burst.
    sv_we = we_cnt;
    cyc(1'b1, 14'h0, 1'b1, 1'b1, 14'h0300, 12'h777, 1'b0);
    for (int k = 0; k < 4; k++) cyc(1'b1, AW'(k), 1'b0, 1'b1, 14'h0055, 12'h555, 1'b0);
    idle(3);
    chk("s6_we_count", we_cnt - sv_we, 1);
    cyc(1'b0, 14'h0, 1'b1, 1'b0, 14'h0300, 12'h000, 1'b0);
    idle(4);
    chk("s6_rdata", cpu_rdata, 12'h777);
    chk("s6_untouched", mem[14'h0055], 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
